// File: rtl/ddr3_wb_arbiter.sv
// Merges NUM_PORTS Wishbone masters onto one DDR3 controller port; an in-order tag FIFO routes acks back.
// Build option: define DDR3_ARB_FIXED_PRIO_EN to hold the priority pointer at port 0 (fixed priority).
module ddr3_wb_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int wb_addr_bits = 24,
    parameter int wb_data_bits = 512,
    parameter int wb_sel_bits  = wb_data_bits / 8,
    parameter int MAX_PENDING  = 16
) (
    input  logic                              i_controller_clk,
    input  logic                              i_rst_n,
    input  logic [NUM_PORTS-1:0]              i_wb_cyc,
    input  logic [NUM_PORTS-1:0]              i_wb_stb,
    input  logic [NUM_PORTS-1:0]              i_wb_we,
    input  logic [NUM_PORTS*wb_addr_bits-1:0] i_wb_addr,
    input  logic [NUM_PORTS*wb_data_bits-1:0] i_wb_data,
    input  logic [NUM_PORTS*wb_sel_bits-1:0]  i_wb_sel,
    output logic [NUM_PORTS-1:0]              o_wb_stall,
    output logic [NUM_PORTS-1:0]              o_wb_ack,
    output logic [wb_data_bits-1:0]           o_wb_data,
    output logic                              o_ddr_cyc,
    output logic                              o_ddr_stb,
    output logic                              o_ddr_we,
    output logic [wb_addr_bits-1:0]           o_ddr_addr,
    output logic [wb_data_bits-1:0]           o_ddr_data,
    output logic [wb_sel_bits-1:0]            o_ddr_sel,
    output logic                              o_ddr_aux,
    input  logic                              i_ddr_stall,
    input  logic                              i_ddr_ack,
    input  logic [wb_data_bits-1:0]           i_ddr_data,
    output logic                              o_err
);

    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW1 = PW + 1;
    localparam int FW  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CW  = FW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(MAX_PENDING);
    localparam logic [PW-1:0]  LAST_PORT  = PW'(NUM_PORTS - 1);
    localparam logic [PW1-1:0] PORT_COUNT = PW1'(NUM_PORTS);

    logic [NUM_PORTS-1:0] req_s;
    logic [PW-1:0]        ptr_r;
    logic [PW-1:0]        sel_idx_s;
    logic [PW-1:0]        next_ptr_s;
    logic [PW1-1:0]       cand_s;
    logic                 found_s;
    logic [PW-1:0]        tag_mem_r [MAX_PENDING];
    logic [FW-1:0]        rd_ptr_r;
    logic [FW-1:0]        wr_ptr_r;
    logic [CW-1:0]        count_r;
    logic [PW-1:0]        head_s;
    logic                 full_s;
    logic                 not_empty_s;
    logic                 push_s;
    logic                 pop_s;

    assign req_s       = i_wb_cyc & i_wb_stb;
    assign full_s      = (count_r == FULL_COUNT);
    assign not_empty_s = (count_r != {CW{1'b0}});
    assign head_s      = tag_mem_r[rd_ptr_r];

    // Rotating search: scan offsets high to low so the nearest requester at/after ptr wins.
    always_comb begin
        sel_idx_s = ptr_r;
        found_s   = 1'b0;
        cand_s    = {PW1{1'b0}};
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr_r} + PW1'(i);
            if (cand_s >= PORT_COUNT) begin
                cand_s = cand_s - PORT_COUNT;
            end else begin
                cand_s = cand_s;
            end
            if (req_s[cand_s[PW-1:0]]) begin
                sel_idx_s = cand_s[PW-1:0];
                found_s   = 1'b1;
            end else begin
                sel_idx_s = sel_idx_s;
                found_s   = found_s;
            end
        end
    end

    assign o_ddr_we   = i_wb_we[sel_idx_s];
    assign o_ddr_addr = i_wb_addr[sel_idx_s*wb_addr_bits +: wb_addr_bits];
    assign o_ddr_data = i_wb_data[sel_idx_s*wb_data_bits +: wb_data_bits];
    assign o_ddr_sel  = i_wb_sel[sel_idx_s*wb_sel_bits +: wb_sel_bits];
    assign o_ddr_stb  = found_s & ~full_s & i_rst_n;
    assign o_ddr_cyc  = (|i_wb_cyc) | not_empty_s;
    assign o_ddr_aux  = 1'b0;
    assign o_wb_data  = i_ddr_data;

    // A full FIFO only frees up on the edge after a pop, so push sees the pre-pop fullness.
    assign push_s = o_ddr_stb & ~i_ddr_stall;
    assign pop_s  = i_ddr_ack & not_empty_s;

    // Stall everybody except the winner, which follows controller back-pressure.
    always_comb begin
        o_wb_stall = {NUM_PORTS{1'b1}};
        if (found_s) begin
            o_wb_stall[sel_idx_s] = i_ddr_stall | full_s | ~i_rst_n;
        end else begin
            o_wb_stall = {NUM_PORTS{1'b1}};
        end
    end

    // Ack goes to the oldest tag's owner, and only if that master is still in its cycle.
    always_comb begin
        o_wb_ack = {NUM_PORTS{1'b0}};
        if (pop_s) begin
            o_wb_ack[head_s] = i_wb_cyc[head_s];
        end else begin
            o_wb_ack = {NUM_PORTS{1'b0}};
        end
    end

    // Pointer advance past the winner, wrapping at the last port.
    always_comb begin
        if (sel_idx_s == LAST_PORT) begin
            next_ptr_s = {PW{1'b0}};
        end else begin
            next_ptr_s = sel_idx_s + PW'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r <= {PW{1'b0}};
        end else if (push_s) begin
`ifdef DDR3_ARB_FIXED_PRIO_EN
            ptr_r <= {PW{1'b0}};
`else
            ptr_r <= next_ptr_s;
`endif
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // In-flight tag FIFO: storage, pointers and occupancy.
    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_r <= {FW{1'b0}};
            wr_ptr_r <= {FW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < MAX_PENDING; i++) begin
                tag_mem_r[i] <= {PW{1'b0}};
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= sel_idx_s;
                wr_ptr_r            <= wr_ptr_r + FW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error: an ack with nothing outstanding.
    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else if (i_ddr_ack && !not_empty_s) begin
            o_err <= 1'b1;
        end else begin
            o_err <= o_err;
        end
    end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Randomized and directed bench for ddr3_wb_arbiter checked against a queue-based reference model.
module tb_ddr3_wb_arbiter;

    localparam int NP = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int MP = 4;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     wb_cyc, wb_stb, wb_we;
    logic [NP*AW-1:0]  wb_addr;
    logic [NP*DW-1:0]  wb_data;
    logic [NP*SW-1:0]  wb_sel;
    logic [NP-1:0]     wb_stall, wb_ack;
    logic [DW-1:0]     wb_rdata;
    logic              ddr_cyc, ddr_stb, ddr_we, ddr_aux;
    logic [AW-1:0]     ddr_addr;
    logic [DW-1:0]     ddr_wdata;
    logic [SW-1:0]     ddr_sel;
    logic              ddr_stall, ddr_ack;
    logic [DW-1:0]     ddr_rdata;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    int m_q[$];
    int m_ptr = 0;
    bit m_err = 1'b0;

    ddr3_wb_arbiter #(
        .NUM_PORTS(NP), .wb_addr_bits(AW), .wb_data_bits(DW), .wb_sel_bits(SW), .MAX_PENDING(MP)
    ) dut (
        .i_controller_clk(clk), .i_rst_n(rst_n),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_sel(wb_sel),
        .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_data(wb_rdata),
        .o_ddr_cyc(ddr_cyc), .o_ddr_stb(ddr_stb), .o_ddr_we(ddr_we),
        .o_ddr_addr(ddr_addr), .o_ddr_data(ddr_wdata), .o_ddr_sel(ddr_sel),
        .o_ddr_aux(ddr_aux),
        .i_ddr_stall(ddr_stall), .i_ddr_ack(ddr_ack), .i_ddr_data(ddr_rdata),
        .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle against the model, then advance the model.
    task automatic step(input logic [NP-1:0] cyc, input logic [NP-1:0] stb,
                        input logic stall, input logic ack);
        int            sel;
        bit            any;
        bit            full;
        logic          e_stb;
        logic [NP-1:0] e_stall;
        logic [NP-1:0] e_ack;
        logic [26:0]   e_bus;
        wb_cyc    = cyc;
        wb_stb    = stb;
        ddr_stall = stall;
        ddr_ack   = ack;
        wb_we     = NP'($urandom);
        ddr_rdata = DW'($urandom);
        for (int k = 0; k < NP; k++) begin
            wb_addr[k*AW +: AW] = AW'($urandom);
            wb_data[k*DW +: DW] = DW'($urandom);
            wb_sel[k*SW +: SW]  = SW'($urandom);
        end
        @(negedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end
        any = 1'b0;
        sel = 0;
        for (int i = 0; i < NP; i++) begin
            int k;
            k = (m_ptr + i) % NP;
            if (!any && cyc[k] && stb[k]) begin
                any = 1'b1;
                sel = k;
            end
        end
        full  = (m_q.size() == MP);
        e_stb = rst_n && any && !full;
        for (int k = 0; k < NP; k++) begin
            e_stall[k] = (any && k == sel) ? (stall || full || !rst_n) : 1'b1;
            e_ack[k]   = rst_n && ack && (m_q.size() > 0) && (m_q[0] == k) && cyc[k];
        end
        check_val("ddr_stb", ddr_stb, e_stb);
        check_val("wb_stall", wb_stall, e_stall);
        check_val("wb_ack", wb_ack, e_ack);
        check_val("ddr_cyc", ddr_cyc, (|cyc) || (m_q.size() > 0));
        check_val("err", err, m_err);
        check_val("wb_rdata", wb_rdata, ddr_rdata);
        check_val("ddr_aux", ddr_aux, 1'b0);
        if (e_stb) begin
            e_bus = {wb_we[sel], wb_addr[sel*AW +: AW], wb_data[sel*DW +: DW], wb_sel[sel*SW +: SW]};
            check_val("ddr_bus", {ddr_we, ddr_addr, ddr_wdata, ddr_sel}, e_bus);
        end
        if (rst_n) begin
            if (ack) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (e_stb && !stall) begin
                m_q.push_back(sel);
`ifdef DDR3_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (sel + 1) % NP;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 2 * MP && m_q.size() > 0; n++) step(4'hF, 4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; wb_cyc = '0; wb_stb = '0; wb_we = '0;
        wb_addr = '0; wb_data = '0; wb_sel = '0;
        ddr_stall = 1'b0; ddr_ack = 1'b0; ddr_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        step(4'b1010, 4'b1010, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        // round-robin with all ports strobing
        step(4'hF, 4'hF, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) step(4'hF, 4'hF, 1'b0, 1'b1);
        drain();
        // ordered acks: port2 then port0
        step(4'b0100, 4'b0100, 1'b0, 1'b0);
        step(4'b0101, 4'b0001, 1'b0, 1'b0);
        step(4'b0101, 4'b0000, 1'b0, 1'b1);
        step(4'b0101, 4'b0000, 1'b0, 1'b1);
        // fill, stall on full, ack+request pops only, push next cycle
        for (int n = 0; n < MP + 1; n++) step(4'hF, 4'hF, 1'b0, 1'b0);
        step(4'hF, 4'hF, 1'b0, 1'b1);
        step(4'hF, 4'hF, 1'b0, 1'b0);
        drain();
        // abort: port1 drops cyc with two tags pending
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        // random traffic, with occasional resets
        for (int n = 0; n < 400; n++) begin
            logic [NP-1:0] c, s;
            for (int k = 0; k < NP; k++) begin
                c[k] = ($urandom_range(0, 9) < 8);
                s[k] = ($urandom_range(0, 9) < 7);
            end
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            step(c, s, ($urandom_range(0, 3) == 0),
                 (m_q.size() > 0) && ($urandom_range(0, 9) < 4));
            rst_n = 1'b1;
        end
        drain();
        // reset with three pending, then a stale ack must flag an error
        for (int n = 0; n < 3; n++) step(4'hF, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(4'hF, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(4'hF, 4'hF, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
